// File: rtl/spi_flash_responder.sv
// SPI mode-0 flash emulator: decodes read/fast-read/JEDEC-ID/status commands
// and serves data from a synchronous memory port with 1-cycle read latency.
//
// state    | meaning
// S_IDLE   | cs high, waiting for select
// S_CMD    | shifting in command byte
// S_ADDR   | shifting in 24-bit address
// S_DUMMY  | fast-read dummy byte
// S_DATA   | shifting out response bytes
// S_IGNORE | unsupported command, miso held low until deselect
module spi_flash_responder #(
  parameter int          ADDR_W   = 24,
  parameter logic [23:0] JEDEC_ID = 24'hEF4016,
  parameter logic [7:0]  STATUS   = 8'h00
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              spi_cs,
  input  logic              spi_sck,
  input  logic              spi_mosi,
  output logic              spi_miso,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [7:0]        mem_data,
  output logic              cmd_valid,
  output logic [7:0]        cmd
);

  typedef enum logic [2:0] {S_IDLE, S_CMD, S_ADDR, S_DUMMY, S_DATA, S_IGNORE} state_t;
  typedef enum logic [1:0] {SRC_MEM, SRC_ID, SRC_STAT} src_t;

  state_t      state, state_next;
  src_t        src;
  logic [1:0]  cs_sync, sck_sync, mosi_sync;
  logic        sck_prev;
  logic        cs_high, sck_rise, sck_fall;
  logic [4:0]  bit_cnt;
  logic [23:0] shift_in, shift_nxt;
  logic [7:0]  cmd_byte, tx_shift;
  logic [1:0]  id_idx;
  logic        fast, rd_pend;

  // cs syncs to 1 on reset so a held-low select is not seen until it settles
  always_ff @(posedge clk) begin
    if (reset) begin
      cs_sync   <= 2'b11;
      sck_sync  <= 2'b00;
      mosi_sync <= 2'b00;
      sck_prev  <= 1'b0;
    end else begin
      cs_sync   <= {cs_sync[0], spi_cs};
      sck_sync  <= {sck_sync[0], spi_sck};
      mosi_sync <= {mosi_sync[0], spi_mosi};
      sck_prev  <= sck_sync[1];
    end
  end

  assign cs_high   = cs_sync[1];
  assign sck_rise  = sck_sync[1] & ~sck_prev;
  assign sck_fall  = ~sck_sync[1] & sck_prev;
  assign shift_nxt = {shift_in[22:0], mosi_sync[1]};
  assign cmd_byte  = shift_nxt[7:0];

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    if (cs_high) begin
      state_next = S_IDLE;
    end else begin
      case (state)
        S_IDLE: state_next = S_CMD;
        S_CMD: if (sck_rise && bit_cnt == 5'd7) begin
          case (cmd_byte)
            8'h03, 8'h0B: state_next = S_ADDR;
            8'h9F, 8'h05: state_next = S_DATA;
            default:      state_next = S_IGNORE;
          endcase
        end
        S_ADDR:  if (sck_rise && bit_cnt == 5'd23) state_next = fast ? S_DUMMY : S_DATA;
        S_DUMMY: if (sck_rise && bit_cnt == 5'd7)  state_next = S_DATA;
        default: state_next = state;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      spi_miso  <= 1'b0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      cmd_valid <= 1'b0;
      cmd       <= 8'h00;
      bit_cnt   <= 5'd0;
      shift_in  <= 24'h0;
      tx_shift  <= 8'h00;
      id_idx    <= 2'd0;
      fast      <= 1'b0;
      src       <= SRC_MEM;
      rd_pend   <= 1'b0;
    end else begin
      cmd_valid <= 1'b0;
      mem_rd    <= 1'b0;
      rd_pend   <= mem_rd;
      if (cs_high) begin
        bit_cnt  <= 5'd0;
        spi_miso <= 1'b0;
        rd_pend  <= 1'b0;
      end else if (sck_rise) begin
        shift_in <= shift_nxt;
        case (state)
          S_CMD: begin
            if (bit_cnt == 5'd7) begin
              bit_cnt   <= 5'd0;
              cmd       <= cmd_byte;
              cmd_valid <= 1'b1;
              fast      <= (cmd_byte == 8'h0B);
              src       <= SRC_MEM;
              if (cmd_byte == 8'h9F) begin
                src      <= SRC_ID;
                tx_shift <= JEDEC_ID[23:16];
                id_idx   <= 2'd1;
              end else if (cmd_byte == 8'h05) begin
                src      <= SRC_STAT;
                tx_shift <= STATUS;
              end
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_ADDR: begin
            if (bit_cnt == 5'd23) begin
              bit_cnt  <= 5'd0;
              mem_addr <= shift_nxt[ADDR_W-1:0];
              mem_rd   <= 1'b1;
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          S_DUMMY: bit_cnt <= (bit_cnt == 5'd7) ? 5'd0 : bit_cnt + 5'd1;
          S_DATA: begin
            if (bit_cnt == 5'd7) begin
              bit_cnt <= 5'd0;
              case (src)
                SRC_MEM: begin
                  mem_rd   <= 1'b1;
                  mem_addr <= mem_addr + 1'b1;
                end
                SRC_ID: begin
                  case (id_idx)
                    2'd0:    tx_shift <= JEDEC_ID[23:16];
                    2'd1:    tx_shift <= JEDEC_ID[15:8];
                    default: tx_shift <= JEDEC_ID[7:0];
                  endcase
                  id_idx <= (id_idx == 2'd2) ? 2'd0 : id_idx + 2'd1;
                end
                default: tx_shift <= STATUS;
              endcase
            end else begin
              bit_cnt <= bit_cnt + 5'd1;
            end
          end
          default: ;
        endcase
      end else if (sck_fall && state == S_DATA) begin
        spi_miso <= tx_shift[7];
        tx_shift <= {tx_shift[6:0], 1'b0};
      end
      // SCK <= clk/8 keeps this capture clear of any falling edge
      if (rd_pend && !cs_high) tx_shift <= mem_data;
    end
  end

endmodule

// File: tb/tb_spi_flash_responder.sv
// Directed bench for spi_flash_responder: bit-banged SPI master, memory model
// returning addr[7:0], scoreboard queues for MISO bytes and read addresses.
module tb_spi_flash_responder;
  localparam int HALF = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        spi_cs = 1'b1;
  logic        spi_sck = 1'b0;
  logic        spi_mosi = 1'b0;
  logic        spi_miso, mem_rd, cmd_valid;
  logic [23:0] mem_addr;
  logic [7:0]  mem_data = 8'h00;
  logic [7:0]  cmd;

  int checks = 0;
  int failures = 0;
  int cv_cnt = 0;
  int rd_double = 0;
  int cv0;
  logic prev_rd = 1'b0;
  logic [7:0]  rx;
  logic [7:0]  exp_q[$];
  logic [23:0] exp_addr_q[$];
  logic [23:0] got_addr_q[$];

  always #5 clk = ~clk;

  spi_flash_responder dut (
    .clk(clk), .reset(reset), .spi_cs(spi_cs), .spi_sck(spi_sck),
    .spi_mosi(spi_mosi), .spi_miso(spi_miso), .mem_rd(mem_rd),
    .mem_addr(mem_addr), .mem_data(mem_data), .cmd_valid(cmd_valid), .cmd(cmd)
  );

  always @(posedge clk) if (mem_rd) mem_data <= mem_addr[7:0];

  always @(negedge clk) begin
    if (mem_rd) got_addr_q.push_back(mem_addr);
    if (cmd_valid) cv_cnt++;
    if (mem_rd && prev_rd) rd_double++;
    prev_rd = mem_rd;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // cs_last raises cs together with the final rise (simultaneous-edge case)
  task automatic spi_bits(input logic [7:0] tx, input int n, input bit cs_last, output logic [7:0] r);
    r = 8'h00;
    for (int i = 0; i < n; i++) begin
      spi_mosi = tx[7-i];
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b1;
      if (cs_last && i == n-1) spi_cs = 1'b1;
      r = {r[6:0], spi_miso};
      repeat (HALF) @(negedge clk);
      spi_sck = 1'b0;
    end
  endtask

  task automatic xfer(input logic [7:0] tx);
    logic [7:0] r;
    spi_bits(tx, 8, 1'b0, r);
  endtask

  task automatic read_check(input string tag, input bit cs_last);
    logic [7:0] r;
    spi_bits(8'h00, 8, cs_last, r);
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $error("FAIL %s observed=%0h expected=none", tag, r);
    end else begin
      check(tag, r, exp_q.pop_front());
    end
  endtask

  task automatic check_addrs(input string tag);
    check({tag, "_count"}, got_addr_q.size(), exp_addr_q.size());
    for (int i = 0; i < exp_addr_q.size() && i < got_addr_q.size(); i++)
      check({tag, "_addr"}, got_addr_q[i], exp_addr_q[i]);
    got_addr_q.delete();
    exp_addr_q.delete();
  endtask

  task automatic cs_low();
    spi_cs = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic cs_high();
    spi_sck = 1'b0;
    spi_cs = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  initial begin
    repeat (4) @(negedge clk);
    check("rst_miso", spi_miso, 1'b0);
    check("rst_mem_rd", mem_rd, 1'b0);
    check("rst_mem_addr", mem_addr, 24'h0);
    check("rst_cmd_valid", cmd_valid, 1'b0);
    check("rst_cmd", cmd, 8'h00);
    reset = 1'b0;
    repeat (4) @(negedge clk);

    // JEDEC ID cycles MSB-first and wraps
    cv0 = cv_cnt;
    exp_q = '{8'hEF, 8'h40, 8'h16, 8'hEF, 8'h40, 8'h16};
    cs_low();
    xfer(8'h9F);
    for (int i = 0; i < 6; i++) read_check("jedec", i == 5);
    cs_high();
    check("jedec_cv", cv_cnt - cv0, 1);
    check("jedec_cmd", cmd, 8'h9F);
    check_addrs("jedec");

    // normal read, cs rises with last rise so no prefetch happens
    exp_q = '{8'h10, 8'h11, 8'h12, 8'h13};
    exp_addr_q = '{24'h10, 24'h11, 24'h12, 24'h13};
    cs_low();
    xfer(8'h03); xfer(8'h00); xfer(8'h00); xfer(8'h10);
    for (int i = 0; i < 4; i++) read_check("read", i == 3);
    cs_high();
    check("read_cmd", cmd, 8'h03);
    check_addrs("read");

    // fast read across the address wrap
    exp_q = '{8'hFE, 8'hFF, 8'h00};
    exp_addr_q = '{24'hFFFFFE, 24'hFFFFFF, 24'h000000};
    cs_low();
    xfer(8'h0B); xfer(8'hFF); xfer(8'hFF); xfer(8'hFE);
    xfer(8'h00);
    for (int i = 0; i < 3; i++) read_check("fast", i == 2);
    cs_high();
    check("fast_cmd", cmd, 8'h0B);
    check_addrs("fast");

    // command aborted mid-byte
    cv0 = cv_cnt;
    cs_low();
    spi_bits(8'h9F, 4, 1'b0, rx);
    cs_high();
    check("abort_cmd_cv", cv_cnt - cv0, 0);
    check("abort_cmd_hold", cmd, 8'h0B);

    // read aborted in the address phase, then status
    cv0 = cv_cnt;
    cs_low();
    xfer(8'h03);
    spi_bits(8'h00, 4, 1'b0, rx);
    cs_high();
    check("abort_rd_cv", cv_cnt - cv0, 1);
    check_addrs("abort_rd");
    cv0 = cv_cnt;
    exp_q = '{8'h00, 8'h00};
    cs_low();
    xfer(8'h05);
    read_check("status", 1'b0);
    read_check("status", 1'b0);
    cs_high();
    check("status_cv", cv_cnt - cv0, 1);
    check("status_cmd", cmd, 8'h05);

    // unknown command and 0xAB keep miso low
    exp_q = '{8'h00, 8'h00};
    cs_low();
    xfer(8'h5A);
    read_check("unk", 1'b0);
    read_check("unk", 1'b0);
    cs_high();
    check("unk_cmd", cmd, 8'h5A);
    exp_q = '{8'h00, 8'h00};
    cs_low();
    xfer(8'hAB);
    read_check("ab", 1'b0);
    read_check("ab", 1'b0);
    cs_high();
    check("ab_cmd", cmd, 8'hAB);
    check_addrs("ignore");

    // reset mid-read while miso carries the MSB of 0xF1
    exp_q = '{8'hF0};
    exp_addr_q = '{24'hF0, 24'hF1};
    cs_low();
    xfer(8'h03); xfer(8'h00); xfer(8'h00); xfer(8'hF0);
    read_check("rst_rd", 1'b0);
    repeat (4) @(negedge clk);
    check("pre_rst_miso", spi_miso, 1'b1);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("midrst_miso", spi_miso, 1'b0);
    check("midrst_mem_rd", mem_rd, 1'b0);
    check("midrst_cmd", cmd, 8'h00);
    check("midrst_cmd_valid", cmd_valid, 1'b0);
    repeat (4) @(negedge clk);
    cs_high();
    check_addrs("rst_rd");
    exp_q = '{8'hEF};
    cs_low();
    xfer(8'h9F);
    read_check("post_rst_id", 1'b1);
    cs_high();
    check("post_rst_cmd", cmd, 8'h9F);

    check("mem_rd_back_to_back", rd_double, 0);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
